// File: rtl/countdown_timer_ssd.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_ssd
// Description : mm:ss BCD countdown timer with start/pause, clear, preset
//               load, timed alarm hold and a 4-digit multiplexed 7-seg output.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer_ssd #(
  parameter int unsigned ALARM_SECS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sec_in,
  input  logic [1:0]  scan,
  input  logic        start,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] preset,
  output logic [7:0]  ssd,
  output logic [3:0]  ssd_ctl,
  output logic        done,
  output logic        running
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] ALARM_LIM = 4'(ALARM_SECS);

  logic        sec_q;
  logic        tick;
  logic [1:0]  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] last_q, last_d;
  logic [3:0]  alarm_q, alarm_d;
  logic [7:0]  ssd_q, ssd_d;
  logic [3:0]  ssd_ctl_q, ssd_ctl_d;
  logic [15:0] count_dec;
  logic [3:0]  digit;

  function automatic logic [15:0] sanitize(input logic [15:0] p);
    logic [15:0] s;
    s[15:12] = (p[15:12] > 4'd9) ? 4'd9 : p[15:12];
    s[11:8]  = (p[11:8]  > 4'd9) ? 4'd9 : p[11:8];
    s[7:4]   = (p[7:4]   > 4'd5) ? 4'd5 : p[7:4];
    s[3:0]   = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
    return s;
  endfunction

  // One-second BCD decrement; each digit borrows only when all lower digits are zero.
  function automatic logic [15:0] dec_bcd(input logic [15:0] c);
    logic [15:0] r;
    r = c;
    if (c[3:0] != 4'd0) begin
      r[3:0] = c[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (c[7:4] != 4'd0) begin
        r[7:4] = c[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (c[11:8] != 4'd0) begin
          r[11:8] = c[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = c[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign tick      = sec_in ^ sec_q;
  assign count_dec = dec_bcd(count_q);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    alarm_d = alarm_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          count_d = last_q;
        end else if (start) begin
          if (count_q != 16'h0000) state_d = ST_RUN;
        end else if (load) begin
          count_d = sanitize(preset);
          last_d  = sanitize(preset);
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d = ST_IDLE;
          count_d = last_q;
        end else if (start) begin
          state_d = ST_PAUSE;
        end else if (tick && count_q != 16'h0000) begin
          count_d = count_dec;
          if (count_dec == 16'h0000) begin
            state_d = ST_DONE;
            alarm_d = 4'd0;
          end
        end
      end
      ST_PAUSE: begin
        if (clear) begin
          state_d = ST_IDLE;
          count_d = last_q;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (clear || start) begin
          state_d = ST_IDLE;
          count_d = last_q;
        end else if (tick) begin
          if (alarm_q + 4'd1 == ALARM_LIM) begin
            state_d = ST_IDLE;
            count_d = last_q;
          end else begin
            alarm_d = alarm_q + 4'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    digit     = count_q[3:0];
    ssd_ctl_d = 4'b1110;
    case (scan)
      2'b00: begin digit = count_q[3:0];   ssd_ctl_d = 4'b1110; end
      2'b01: begin digit = count_q[7:4];   ssd_ctl_d = 4'b1101; end
      2'b10: begin digit = count_q[11:8];  ssd_ctl_d = 4'b1011; end
      default: begin digit = count_q[15:12]; ssd_ctl_d = 4'b0111; end
    endcase
    // dp on the minutes-ones digit acts as the colon
    ssd_d = {seg7(digit), (scan == 2'b10) ? 1'b0 : 1'b1};
    if (state_q == ST_DONE && !sec_in) ssd_d = 8'hFF;
  end

  always_ff @(posedge clk) begin
    sec_q <= sec_in;
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= 16'h0000;
      last_q    <= 16'h0000;
      alarm_q   <= 4'd0;
      ssd_q     <= 8'hFF;
      ssd_ctl_q <= 4'hF;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      last_q    <= last_d;
      alarm_q   <= alarm_d;
      ssd_q     <= ssd_d;
      ssd_ctl_q <= ssd_ctl_d;
    end
  end

  assign ssd     = ssd_q;
  assign ssd_ctl = ssd_ctl_q;
  assign done    = (state_q == ST_DONE);
  assign running = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_ssd.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer_ssd
// Description : Directed self-checking bench for countdown_timer_ssd.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer_ssd;

  logic        clk = 1'b0;
  logic        reset, sec_in, start, clear, load;
  logic [1:0]  scan;
  logic [15:0] preset;
  logic [7:0]  ssd;
  logic [3:0]  ssd_ctl;
  logic        done, running;
  int          n_tests = 0;
  int          n_fail  = 0;

  countdown_timer_ssd #(.ALARM_SECS(5)) dut (
    .clk(clk), .reset(reset), .sec_in(sec_in), .scan(scan), .start(start),
    .clear(clear), .load(load), .preset(preset), .ssd(ssd), .ssd_ctl(ssd_ctl),
    .done(done), .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg(input logic [3:0] d, input logic dp);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b0000001;  4'd1: s = 7'b1001111;
      4'd2: s = 7'b0010010;  4'd3: s = 7'b0000110;
      4'd4: s = 7'b1001100;  4'd5: s = 7'b0100100;
      4'd6: s = 7'b0100000;  4'd7: s = 7'b0001111;
      4'd8: s = 7'b0000000;  default: s = 7'b0000100;
    endcase
    return {s, dp};
  endfunction

  function automatic logic [31:0] exp_disp(input logic [15:0] c);
    return {seg(c[15:12], 1'b1), seg(c[11:8], 1'b0), seg(c[7:4], 1'b1), seg(c[3:0], 1'b1)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_disp(output logic [31:0] v);
    v = '0;
    for (int i = 0; i < 4; i++) begin
      scan = 2'(i);
      step();
      v[8*i +: 8] = ssd;
    end
  endtask

  task automatic check_count(input string tag, input logic [15:0] c);
    logic [31:0] v;
    read_disp(v);
    check(tag, v, exp_disp(c));
  endtask

  task automatic tick();
    sec_in = ~sec_in;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] p);
    preset = p; load = 1'b1; step(); load = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1; sec_in = 1'b0; start = 1'b0; clear = 1'b0; load = 1'b0;
    scan = 2'b00; preset = 16'h0000;
    step(); step();
    check("rst_ssd", 32'(ssd), 32'hFF);
    check("rst_ctl", 32'(ssd_ctl), 32'hF);
    check("rst_flags", {30'b0, done, running}, 32'd0);
    reset = 1'b0;
    check_count("rst_count", 16'h0000);

    // full countdown from 01:02 into DONE
    do_load(16'h0102);
    check_count("load_0102", 16'h0102);
    pulse_start();
    check("run_after_start", 32'(running), 32'd1);
    for (int t = 1; t <= 62; t++) begin
      tick();
      if (t == 1)  check_count("cnt_0101", 16'h0101);
      if (t == 2)  check_count("cnt_0100", 16'h0100);
      if (t == 3)  check_count("cnt_0059", 16'h0059);
      if (t == 61) begin
        check_count("cnt_0001", 16'h0001);
        check("not_done_61", 32'(done), 32'd0);
      end
      if (t == 62) check("done_62", {30'b0, done, running}, 32'd2);
    end

    // DONE blink, alarm hold and automatic return
    read_disp(v);
    check("blank_sec0", v, 32'hFFFFFFFF);
    check("blank_ctl", 32'(ssd_ctl), 32'h7);
    tick();
    check_count("done_0000", 16'h0000);
    for (int t = 2; t <= 4; t++) tick();
    check("done_after4", 32'(done), 32'd1);
    tick();
    check("idle_after5", {30'b0, done, running}, 32'd0);
    check_count("alarm_reload", 16'h0102);

    // start coinciding with tick pauses without counting
    do_load(16'h0005);
    pulse_start();
    check("run_0005", 32'(running), 32'd1);
    start = 1'b1; sec_in = ~sec_in; step(); start = 1'b0;
    check("paused", {30'b0, done, running}, 32'd0);
    for (int t = 0; t < 3; t++) tick();
    check_count("pause_frozen", 16'h0005);
    pulse_start();
    check("resume", 32'(running), 32'd1);
    tick();
    check_count("cnt_0004", 16'h0004);

    // clear beats start in RUN
    clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
    check("clr_start_idle", {30'b0, done, running}, 32'd0);
    check_count("clr_reload", 16'h0005);

    // sanitize and one-cycle display latency
    do_load(16'hFA7C);
    scan = 2'b10;
    step();
    check("san_ssd", 32'(ssd), 32'h08);
    check("san_ctl", 32'(ssd_ctl), 32'hB);
    check_count("san_9959", 16'h9959);

    // start beats load in IDLE
    preset = 16'h0003; load = 1'b1; start = 1'b1; step(); load = 1'b0; start = 1'b0;
    check("start_over_load", 32'(running), 32'd1);
    tick();
    check_count("cnt_9958", 16'h9958);
    clear = 1'b1; step(); clear = 1'b0;
    check_count("clr_9959", 16'h9959);

    // reset mid-RUN with sec_in high and a competing start
    pulse_start();
    tick();
    reset = 1'b1; sec_in = 1'b1; start = 1'b1; step();
    reset = 1'b0; start = 1'b0;
    check("midrst_ssd", 32'(ssd), 32'hFF);
    check("midrst_ctl", 32'(ssd_ctl), 32'hF);
    check("midrst_flags", {30'b0, done, running}, 32'd0);
    check_count("midrst_count", 16'h0000);
    pulse_start();
    check("zero_start_idle", 32'(running), 32'd0);
    do_load(16'h0001);
    pulse_start();
    check("run_0001", 32'(running), 32'd1);
    tick();
    check("done_0001", 32'(done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/countdown_timer_ssd.md
COUNTDOWN_TIMER_SSD -- requirements
Module: countdown_timer_ssd

Interface
REQ-001 Parameter: ALARM_SECS, default 5, number of seconds DONE is held before automatic return to IDLE (range 1..15).
REQ-002 clk  input  1  system clock, 100 MHz; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sec_in  input  1  divided second clock from the upstream divider; toggles once per second.
REQ-005 scan  input  2  digit-scan select from the upstream divider (counter bits [17:16]).
REQ-006 start  input  1  one-cycle pulse, already debounced; start/pause toggle.
REQ-007 clear  input  1  one-cycle pulse, already debounced; abort and reload.
REQ-008 load  input  1  one-cycle pulse; capture preset in IDLE.
REQ-009 preset  input  16  BCD {min_t, min_o, sec_t, sec_o}.
REQ-010 ssd  output  8  active-low segments {a,b,c,d,e,f,g,dp}.
REQ-011 ssd_ctl  output  4  active-low digit enables, bit 0 = rightmost digit.
REQ-012 done  output  1  high while state is DONE.
REQ-013 running  output  1  high while state is RUN.

Function
REQ-014 Tick: sec_d register samples sec_in every cycle; tick = sec_in XOR sec_d (one-cycle pulse per sec_in edge, i.e. once per second).
REQ-015 Count register: 4 BCD digits mm:ss; sec_t range 0-5; all others 0-9.
REQ-016 States: IDLE, RUN, PAUSE, DONE.
REQ-017 Event priority within one cycle: clear > start > load > tick.
REQ-018 IDLE: load -> count <= sanitized preset; start with count != 00:00 -> RUN; start with count == 00:00 -> stay in IDLE; tick has no effect.
REQ-019 Sanitize: any digit >9 becomes 9; sec_t >5 becomes 5; applied per digit at load.
REQ-020 RUN: tick -> decrement by one second with BCD borrow (xx:00 -> (xx-1):59; 10:00 -> 09:59).
REQ-021 RUN: when a decrement produces 00:00 -> DONE on the same edge; alarm counter <= 0.
REQ-022 RUN: start -> PAUSE; if start and tick coincide, the count does not change that cycle.
REQ-023 PAUSE: count frozen; start -> RUN; load and tick are ignored.
REQ-024 clear in RUN, PAUSE or DONE -> IDLE with count <= last loaded value; clear in IDLE -> count <= last loaded value.
REQ-025 DONE: count held at 00:00; each tick increments the alarm counter; on reaching ALARM_SECS -> IDLE with count <= last loaded value.
REQ-026 DONE: start or clear -> IDLE immediately with count <= last loaded value.
REQ-027 Display digit map: scan 00 -> sec_o, ssd_ctl 1110; 01 -> sec_t, 1101; 10 -> min_o, 1011; 11 -> min_t, 0111.
REQ-028 dp is lit (0) only on the min_o digit, to act as the colon.
REQ-029 Encoding without dp ({a..g,dp}): 0=0000001_1, 1=1001111_1, 2=0010010_1, 3=0000110_1, 4=1001100_1, 5=0100100_1, 6=0100000_1, 7=0001111_1, 8=0000000_1, 9=0000100_1.
REQ-030 Blink: in DONE, while sec_in == 0, ssd = 8'hFF (blank); ssd_ctl still scans.
REQ-031 ssd and ssd_ctl are registered, with one-cycle latency from scan, count or state.
REQ-032 done and running are decoded from the state register (no extra latency).

Reset
REQ-033 On reset: state IDLE; count 00:00; last loaded value 00:00; alarm counter 0; ssd 8'hFF; ssd_ctl 4'hF; done 0; running 0.
REQ-034 During reset, sec_d <= sec_in, so no spurious tick occurs on the first cycle after reset.
REQ-035 Reset asserted mid-RUN overrides all other inputs in that cycle.

Verification
REQ-036 load preset 16'h0102, start, 62 ticks -> count steps 01:02, 01:01 ... 01:00, 00:59 ... 00:00; done=1 on the 62nd tick edge.
REQ-037 preset 16'hFA7C, load -> count 99:59; scan=10 -> ssd=8'b00001000 and ssd_ctl=1011 one cycle later.
REQ-038 RUN at 00:05, start with a coincident tick -> PAUSE with count 00:05; 3 ticks -> still 00:05; start -> RUN.
REQ-039 In DONE with ALARM_SECS=5: 5 ticks -> IDLE with count = preset; blank ssd while sec_in=0.
REQ-040 IDLE with count 00:00, start -> stays IDLE, running=0; clear and start in the same cycle in RUN -> IDLE.
REQ-041 reset pulse mid-RUN with sec_in=1 -> all REQ-033 values; no tick in the following cycle.
